// File: rtl/jk_mod_down_counter.sv
// -----------------------------------------------------------------------------
// jk_mod_down_counter
//
// Purpose:
//   Synchronous modulo-MOD down counter built from one JK flip-flop per state
//   bit. A combinational next-state function picks the target count, and each
//   bit's J/K pair is then derived from that target. Supports a synchronous
//   load with clamping to MOD-1, a count enable, and a combinational
//   terminal-count strobe.
//
// Optional feature (macro JK_DOWN_COUNTER_UPDN_EN):
//   When defined, an up_dn input is added after en. up_dn=1 counts up
//   (0..MOD-1, then wraps to 0), and tc flags q==MOD-1 while en is high.
//   up_dn=0 is identical to the base down counter.
//
// Parameters:
//   WIDTH sets the state and port width in bits; the count modulus is legal
//   from 2 up to 2**WIDTH.
//
// Ports:
//   clk      in   rising-edge clock
//   reset_n  in   asynchronous active-low reset; forces q to MOD-1
//   en       in   count enable
//   up_dn    in   count direction, 1 = up (only with JK_DOWN_COUNTER_UPDN_EN)
//   load     in   synchronous load strobe; takes priority over en
//   load_val in   value to load; values >= MOD load MOD-1
//   q        out  current count
//   tc       out  terminal count (q at end of range and en), combinational
//   zero     out  q == 0, combinational
// -----------------------------------------------------------------------------

// JK flip-flop cell with async active-low reset to a per-instance value.
// Cell encoding for {j,k}: 00 hold, 01 clear, 10 set, 11 toggle.
module jk_down_ff_cell #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic j_i,
  input  logic k_i,
  output logic q_o
);

  logic q_q;

  // JK storage element; reset acts as clear or preset depending on RST_VAL
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q_q <= RST_VAL;
    end else begin
      case ({j_i, k_i})
        2'b00:   q_q <= q_q;
        2'b01:   q_q <= 1'b0;
        2'b10:   q_q <= 1'b1;
        2'b11:   q_q <= ~q_q;
        default: q_q <= q_q;
      endcase
    end
  end

  assign q_o = q_q;

endmodule

module jk_mod_down_counter #(
  parameter int WIDTH = 3,
  parameter int MOD   = 7
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
`ifdef JK_DOWN_COUNTER_UPDN_EN
  input  logic             up_dn,
`endif
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             zero
);

  localparam int               WIDTH_EXT = WIDTH + 1;
  localparam logic [WIDTH-1:0] MAX_VAL   = WIDTH'(MOD - 1);
  localparam logic [WIDTH:0]   MOD_EXT   = WIDTH_EXT'(MOD);

  // Reject moduli that cannot be represented or cannot count
  if ((MOD < 2) || (MOD > (2 ** WIDTH))) begin : g_bad_mod
    $error("jk_mod_down_counter: MOD=%0d outside 2..2**WIDTH (WIDTH=%0d)", MOD, WIDTH);
  end

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;
  logic [WIDTH-1:0] j_s;
  logic [WIDTH-1:0] k_s;
  logic             up_mode_s;
  logic             illegal_s;
  logic             at_end_s;
  logic [WIDTH-1:0] load_clamped_s;

`ifdef JK_DOWN_COUNTER_UPDN_EN
  assign up_mode_s = up_dn;
`else
  assign up_mode_s = 1'b0;
`endif

  // Only reachable when MOD < 2**WIDTH (e.g. an upset flips a bit)
  assign illegal_s      = ({1'b0, cnt_q} >= MOD_EXT);
  assign load_clamped_s = (load_val > MAX_VAL) ? MAX_VAL : load_val;

  // Next-count selection: load, then illegal-state recovery, then count/hold
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_clamped_s;
    end else if (illegal_s) begin
      cnt_d = up_mode_s ? {WIDTH{1'b0}} : MAX_VAL;
    end else if (en) begin
      if (up_mode_s) begin
        cnt_d = (cnt_q == MAX_VAL) ? {WIDTH{1'b0}} : (cnt_q + {{(WIDTH-1){1'b0}}, 1'b1});
      end else begin
        cnt_d = (cnt_q == {WIDTH{1'b0}}) ? MAX_VAL : (cnt_q - {{(WIDTH-1){1'b0}}, 1'b1});
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // J/K drive: set bits that rise, clear bits that fall, hold the rest
  always_comb begin
    j_s = cnt_d & ~cnt_q;
    k_s = ~cnt_d & cnt_q;
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    jk_down_ff_cell #(
      .RST_VAL (MAX_VAL[i])
    ) u_cell (
      .clk_i  (clk),
      .rst_ni (reset_n),
      .j_i    (j_s[i]),
      .k_i    (k_s[i]),
      .q_o    (cnt_q[i])
    );
  end

  // End of range depends on direction: 0 when counting down, MOD-1 when up
  always_comb begin
    if (up_mode_s) begin
      at_end_s = (cnt_q == MAX_VAL);
    end else begin
      at_end_s = (cnt_q == {WIDTH{1'b0}});
    end
  end

  assign q    = cnt_q;
  assign tc   = at_end_s & en;
  assign zero = (cnt_q == {WIDTH{1'b0}});

endmodule

// File: tb/tb_jk_mod_down_counter.sv
// -----------------------------------------------------------------------------
// tb_jk_mod_down_counter
//
// Self-checking bench for jk_mod_down_counter (WIDTH=3, MOD=7). The expected
// count is kept as an integer and advanced with plain modular arithmetic.
// Build with JK_DOWN_COUNTER_UPDN_EN defined to also exercise up counting.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_jk_mod_down_counter;

  localparam int WIDTH = 3;
  localparam int MOD   = 7;

  logic             clk;
  logic             reset_n;
  logic             en;
  logic             up_dn;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] q;
  logic             tc;
  logic             zero;

  int exp_q;
  int n_cmp;
  int n_err;

  jk_mod_down_counter #(
    .WIDTH (WIDTH),
    .MOD   (MOD)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .en       (en),
`ifdef JK_DOWN_COUNTER_UPDN_EN
    .up_dn    (up_dn),
`endif
    .load     (load),
    .load_val (load_val),
    .q        (q),
    .tc       (tc),
    .zero     (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: next count from the current count and the sampled controls
  function automatic int model_next(int cur, logic e, logic l, int lv, logic up);
    if (l) return (lv > MOD - 1) ? MOD - 1 : lv;
    if (!e) return cur;
    if (up) return (cur == MOD - 1) ? 0 : cur + 1;
    return (cur == 0) ? MOD - 1 : cur - 1;
  endfunction

  function automatic logic model_tc(int cur, logic e, logic up);
    if (!e) return 1'b0;
    return up ? (cur == MOD - 1) : (cur == 0);
  endfunction

  // One clock edge: advance the model with the controls seen at the edge
  task automatic tick();
    @(posedge clk);
    exp_q = model_next(exp_q, en, load, int'(load_val), up_dn);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b1; en = 1'b1; load = 1'b0; load_val = '0; up_dn = 1'b0;
    #2 reset_n = 1'b0;
    exp_q = MOD - 1;
    #1;
    n_cmp++;
    if (q !== WIDTH'(exp_q)) begin n_err++; $display("FAIL reset_q: got %0d expected %0d", q, exp_q); end
    n_cmp++;
    if (tc !== 1'b0) begin n_err++; $display("FAIL reset_tc: got %0b expected 0", tc); end
    n_cmp++;
    if (zero !== 1'b0) begin n_err++; $display("FAIL reset_zero: got %0b expected 0", zero); end
    @(negedge clk);
    en = 1'b0;
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (q !== 3'd6) begin n_err++; $display("FAIL reset_hold[%0d]: got %0d expected 6", i, q); end
    end
  endtask

  task automatic test_down_sequence();
    int seq [8] = '{5, 4, 3, 2, 1, 0, 6, 5};
    en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      n_cmp++;
      if (tc !== (exp_q == 0)) begin n_err++; $display("FAIL down_tc[%0d]: got %0b expected %0b (q=%0d)", i, tc, exp_q == 0, q); end
      n_cmp++;
      if (zero !== (exp_q == 0)) begin n_err++; $display("FAIL down_zero[%0d]: got %0b expected %0b", i, zero, exp_q == 0); end
      tick();
      n_cmp++;
      if ((q !== WIDTH'(seq[i])) || (exp_q != seq[i])) begin
        n_err++; $display("FAIL down_q[%0d]: got %0d expected %0d", i, q, seq[i]);
      end
    end
    en = 1'b0;
  endtask

  task automatic test_load();
    load = 1'b1; load_val = 3'd4; en = 1'b0;
    tick();
    n_cmp++;
    if (q !== 3'd4) begin n_err++; $display("FAIL load_4: got %0d expected 4", q); end
    load_val = 3'd2; en = 1'b1;
    tick();
    n_cmp++;
    if (q !== 3'd2) begin n_err++; $display("FAIL load_over_en: got %0d expected 2", q); end
    load = 1'b0;
    tick();
    n_cmp++;
    if (q !== 3'd1) begin n_err++; $display("FAIL load_then_count: got %0d expected 1", q); end
    load = 1'b1; load_val = 3'd7;
    tick();
    n_cmp++;
    if (q !== 3'd6) begin n_err++; $display("FAIL load_clamp: got %0d expected 6", q); end
    load = 1'b0; en = 1'b0;
  endtask

  task automatic test_mid_reset();
    load = 1'b1; load_val = 3'd3; en = 1'b1;
    tick();
    load = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    exp_q = MOD - 1;
    #1;
    n_cmp++;
    if (q !== 3'd6) begin n_err++; $display("FAIL midreset_q: got %0d expected 6", q); end
    n_cmp++;
    if (tc !== 1'b0) begin n_err++; $display("FAIL midreset_tc: got %0b expected 0", tc); end
    #1 reset_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_cmp++;
      if (q !== WIDTH'(5 - i)) begin n_err++; $display("FAIL midreset_resume[%0d]: got %0d expected %0d", i, q, 5 - i); end
    end
    en = 1'b0;
  endtask

  task automatic test_gated_zero();
    load = 1'b1; load_val = 3'd0; en = 1'b0;
    tick();
    load = 1'b0;
    tick();
    n_cmp++;
    if (q !== 3'd0) begin n_err++; $display("FAIL gz_hold: got %0d expected 0", q); end
    n_cmp++;
    if (tc !== 1'b0) begin n_err++; $display("FAIL gz_tc_off: got %0b expected 0", tc); end
    n_cmp++;
    if (zero !== 1'b1) begin n_err++; $display("FAIL gz_zero: got %0b expected 1", zero); end
    en = 1'b1;
    #1;
    n_cmp++;
    if (tc !== 1'b1) begin n_err++; $display("FAIL gz_tc_on: got %0b expected 1", tc); end
    tick();
    en = 1'b0;
    #1;
    n_cmp++;
    if (q !== 3'd6) begin n_err++; $display("FAIL gz_wrap: got %0d expected 6", q); end
    n_cmp++;
    if (tc !== 1'b0) begin n_err++; $display("FAIL gz_tc_after: got %0b expected 0", tc); end
  endtask

`ifdef JK_DOWN_COUNTER_UPDN_EN
  task automatic test_updn();
    int seq [8] = '{1, 2, 3, 4, 5, 6, 0, 1};
    load = 1'b1; load_val = 3'd0; en = 1'b0; up_dn = 1'b1;
    tick();
    load = 1'b0; en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      n_cmp++;
      if (tc !== (exp_q == MOD - 1)) begin n_err++; $display("FAIL up_tc[%0d]: got %0b expected %0b", i, tc, exp_q == MOD - 1); end
      tick();
      n_cmp++;
      if (q !== WIDTH'(seq[i])) begin n_err++; $display("FAIL up_q[%0d]: got %0d expected %0d", i, q, seq[i]); end
    end
    up_dn = 1'b0;
    tick();
    n_cmp++;
    if (q !== 3'd0) begin n_err++; $display("FAIL updn_flip: got %0d expected 0", q); end
    en = 1'b0;
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      en       = ($urandom_range(0, 9) < 7);
      load     = ($urandom_range(0, 9) < 2);
      load_val = WIDTH'($urandom_range(0, 7));
`ifdef JK_DOWN_COUNTER_UPDN_EN
      up_dn    = $urandom_range(0, 1) != 0;
`else
      up_dn    = 1'b0;
`endif
      #1;
      n_cmp++;
      if (tc !== model_tc(exp_q, en, up_dn)) begin
        n_err++; $display("FAIL rand_tc[%0d]: got %0b expected %0b", i, tc, model_tc(exp_q, en, up_dn));
      end
      n_cmp++;
      if (zero !== (exp_q == 0)) begin n_err++; $display("FAIL rand_zero[%0d]: got %0b expected %0b", i, zero, exp_q == 0); end
      tick();
      n_cmp++;
      if (q !== WIDTH'(exp_q)) begin n_err++; $display("FAIL rand_q[%0d]: got %0d expected %0d", i, q, exp_q); end
    end
    en = 1'b0; load = 1'b0; up_dn = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    exp_q = MOD - 1;
    test_reset();
    test_down_sequence();
    test_load();
    test_mid_reset();
    test_gated_zero();
`ifdef JK_DOWN_COUNTER_UPDN_EN
    test_updn();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
